// File: rtl/id_alu_issue.sv
// ---------------------------------------------------------------------------
// id_alu_issue
//   Decode-to-execute issue stage for the RV32I integer ALU instructions.
//   Each accepted instruction is decoded into an ALU operation code and two
//   operands. The result is registered, so it reaches the EX side one cycle
//   after it is accepted.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : decode-side handshake
//   instr, pc           : RV32I instruction word and its PC
//   rs1_data, rs2_data  : register-file read data for the instruction
//   flush               : discard the held and the incoming instruction
//   ex_valid, ex_ready  : EX-side handshake
//   ALUCode, A, B       : registered ALU operation and operands
//   rd, reg_write       : destination register and its write enable
//   ex_illegal          : the issued instruction did not decode
//   ex_pc               : PC of the issued instruction
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. A producer holds its payload stable while valid=1 and ready=0.
// in_ready is combinational: the stage takes a new instruction when its
// output slot is empty, or when EX drains the slot on the same edge, or when
// flush is asserted. A flush drops the incoming instruction even if it is
// presented.
// ---------------------------------------------------------------------------
module id_alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [3:0]  ALUCode,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        ex_illegal,
    output logic [31:0] ex_pc
);

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_PASS_B = 4'd2;
    localparam logic [3:0] ALU_AND    = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_OR     = 4'd5;
    localparam logic [3:0] ALU_SLL    = 4'd6;
    localparam logic [3:0] ALU_SRL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SLT    = 4'd9;
    localparam logic [3:0] ALU_SLTU   = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'b0};

    // The rs1 field is resolved by the register file, not here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr[19:15];

    // funct3 -> operation for the funct7=0000000 (base) encodings shared by
    // OP and OP-IMM. Bit 5 of funct7 selects SUB/SRA and is handled by the
    // caller.
    function automatic logic [3:0] base_code(input logic [2:0] f3);
        logic [3:0] code;
        code = ALU_ADD;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic        dec_illegal;
    logic [3:0]  dec_code;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_reg_write;
    logic        is_shift;

    always_comb begin
        dec_illegal = 1'b0;
        dec_code    = ALU_ADD;
        dec_a       = rs1_data;
        dec_b       = 32'd0;
        is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec_code = base_code(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_code = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_code = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
                // Shift amounts are trimmed to 5 bits so EX can shift by all of B.
                dec_b = is_shift ? {27'd0, rs2_data[4:0]} : rs2_data;
            end

            OPC_OP_IMM: begin
                dec_code = base_code(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_code = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end
                dec_b = is_shift ? {27'd0, instr[24:20]} : imm_i;
            end

            OPC_LUI: begin
                dec_code = ALU_PASS_B;
                dec_b    = imm_u;
            end

            OPC_AUIPC: begin
                dec_code = ALU_ADD;
                dec_a    = pc;
                dec_b    = imm_u;
            end

            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        // Illegal instructions still issue, but carry a harmless payload.
        if (dec_illegal) begin
            dec_code = ALU_ADD;
            dec_a    = 32'd0;
            dec_b    = 32'd0;
        end

        dec_reg_write = !dec_illegal && (rd_field != 5'd0);
    end

    // -----------------------------------------------------------------------
    // Handshake and output register
    // -----------------------------------------------------------------------
    logic accept;

    assign in_ready = flush || !ex_valid || ex_ready;
    assign accept   = in_valid && in_ready && !flush;

    // ex_valid is the only control state; everything else is payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // The payload only loads on accept, so it stays put when ex_valid drops
    // through a drain or a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUCode    <= 4'd0;
            A          <= 32'd0;
            B          <= 32'd0;
            rd         <= 5'd0;
            reg_write  <= 1'b0;
            ex_illegal <= 1'b0;
            ex_pc      <= 32'd0;
        end else if (accept) begin
            ALUCode    <= dec_code;
            A          <= dec_a;
            B          <= dec_b;
            rd         <= rd_field;
            reg_write  <= dec_reg_write;
            ex_illegal <= dec_illegal;
            ex_pc      <= pc;
        end
    end

endmodule

// File: doc/id_alu_issue.md
ID_ALU_ISSUE -- requirements
Module: id_alu_issue

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 each, decode-side handshake; transfer when both high on a clk edge.
REQ-004 SHALL have instr, pc, rs1_data, rs2_data, inputs, 32 each, RV32I instruction, its PC, register-file read data.
REQ-005 SHALL have flush, input, 1, discard held and incoming instruction.
REQ-006 SHALL have ex_valid, output, 1, and ex_ready, input, 1, EX-side handshake.
REQ-007 SHALL have ALUCode, output, 4; A, B, outputs, 32; rd, output, 5; reg_write, output, 1; ex_illegal, output, 1; ex_pc, output, 32 -- all registered.

Function
REQ-008 SHALL encode ALUCode: 0 ADD, 1 SUB, 2 PASS_B, 3 AND, 4 XOR, 5 OR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU; 11-15 never issued.
REQ-009 SHALL decode OP (0110011): funct7 0000000 with funct3 000/001/010/011/100/101/110/111 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; funct7 0100000 with funct3 000 -> SUB, 101 -> SRA; any other funct7 -> illegal.
REQ-010 SHALL decode OP-IMM (0010011): same funct3 mapping, no SUBI; funct3 001 requires imm[11:5]=0000000; funct3 101 requires 0000000 (SRL) or 0100000 (SRA); else illegal.
REQ-011 SHALL decode LUI (0110111) -> PASS_B, B = {instr[31:12],12'b0}; AUIPC (0010111) -> ADD, A = pc, B = {instr[31:12],12'b0}.
REQ-012 SHALL set A = rs1_data except AUIPC; B = rs2_data for OP, sign-extended instr[31:20] for OP-IMM non-shift.
REQ-013 SHALL, for all shift codes (6,7,8), drive B = {27'b0, amount[4:0]} (rs2_data[4:0] or instr[24:20]); EX shifts by full B.
REQ-014 SHALL, for any other opcode or illegal encoding, issue ex_illegal=1, reg_write=0, ALUCode=0, A=B=0.
REQ-015 SHALL set reg_write=1 for legal instructions with rd!=0, else 0.
REQ-016 SHALL have latency 1: instruction accepted at edge N appears on outputs with ex_valid=1 after edge N.
REQ-017 SHALL drive in_ready = !ex_valid || ex_ready (combinational); accept-and-drain in same cycle sustains one instruction per cycle.
REQ-018 SHALL hold all outputs stable while ex_valid=1 and ex_ready=0.
REQ-019 SHALL load ex_valid=0 on an edge with ex_ready=1 and no accept.
REQ-020 SHALL, when flush=1, force in_ready=1, drop any instruction presented, and clear ex_valid at next edge; flush overrides stall and accept.
REQ-021 SHALL leave data outputs unchanged when ex_valid is cleared (only ex_valid gates them).

Reset
REQ-022 SHALL, while rst_n=0, immediately force ex_valid=0, reg_write=0, ex_illegal=0, ALUCode=0, A=B=0, rd=0, ex_pc=0.
REQ-023 SHALL drive in_ready=1 from first cycle after reset release; reset mid-stall drops held instruction.

Verification
REQ-024 ADD: instr=0x002081B3, rs1_data=5, rs2_data=7, ex_ready=1 -> next cycle ex_valid=1, ALUCode=0, A=5, B=7, rd=3, reg_write=1; 0x402081B3 -> ALUCode=1.
REQ-025 SRAI: instr=0x40435293, rs1_data=0x80000000 -> ALUCode=8, B=4, rd=5; SLL with rs2_data=0x25 -> ALUCode=6, B=5.
REQ-026 LUI/illegal: 0x123450B7 -> ALUCode=2, B=0x12345000, rd=1; 0x00000073 -> ex_illegal=1, reg_write=0, ex_valid=1.
REQ-027 Stall: issue two back-to-back, ex_ready=0 for 3 cycles -> first held unchanged, in_ready=0; second appears one cycle after ex_ready=1.
REQ-028 Flush: flush=1 during stall with in_valid=1 -> ex_valid=0 next cycle, in_ready=1, flushed instruction never appears.
REQ-029 Reset: rst_n=0 asserted mid-stall, asynchronous to clk -> all outputs 0 before next edge; in_ready=1 after release.
